// File: rtl/sd_cmd_tx_if.sv
// -----------------------------------------------------------------------------
// sd_cmd_tx_if
// Handshake/bus bundle between the SD command sequencer and sd_cmd_tx.
// Signal names are prefixed from the serializer's point of view.
//   i_bit_ce     : one-cycle SD bit strobe
//   i_start      : request to send a frame (sampled only while idle)
//   i_cmd_index  : 6-bit command index, captured at accept
//   i_arg        : 32-bit command argument, captured at accept
//   o_cmd_out    : serial CMD bit (registered)
//   o_cmd_oe     : CMD line driver enable (registered)
//   o_busy       : frame accepted and not yet complete
//   o_done       : one-cycle pulse when the frame completes
// Modports: master = sequencer side, slave = serializer side.
// -----------------------------------------------------------------------------
interface sd_cmd_tx_if;
    logic        i_bit_ce;
    logic        i_start;
    logic [5:0]  i_cmd_index;
    logic [31:0] i_arg;
    logic        o_cmd_out;
    logic        o_cmd_oe;
    logic        o_busy;
    logic        o_done;

    modport master (
        output i_bit_ce, i_start, i_cmd_index, i_arg,
        input  o_cmd_out, o_cmd_oe, o_busy, o_done
    );

    modport slave (
        input  i_bit_ce, i_start, i_cmd_index, i_arg,
        output o_cmd_out, o_cmd_oe, o_busy, o_done
    );
endinterface

// File: rtl/sd_cmd_tx.sv
// -----------------------------------------------------------------------------
// sd_cmd_tx
// Serializes a 48-bit SD command frame onto the CMD line, MSB first, one bit
// per bit strobe: start bit, transmission bit, index, argument, CRC7, end bit.
// The first 40 bits also feed the CRC7 stage, whose result is appended.
// Ports:
//   i_clk : system clock, all state changes on the rising edge
//   i_rst : synchronous active-high reset
//   bus   : sd_cmd_tx_if.slave (bit strobe, start, index, argument in;
//           cmd_out, cmd_oe, busy, done out)
// -----------------------------------------------------------------------------
module sd_cmd_tx (
    input  logic          i_clk,
    input  logic          i_rst,
    sd_cmd_tx_if.slave    bus
);
    typedef enum logic [2:0] {StIdle, StHdr, StCrc, StEnd, StFin} state_e;

    state_e      r_state;
    logic [39:0] r_shift;
    logic [6:0]  r_crc_sr;
    logic [5:0]  r_cnt;
    logic        r_cmd_out;
    logic        r_cmd_oe;
    logic        r_busy;
    logic        r_done;

    // CRC7 stage (x^7 + x^3 + 1) and its control signals.
    logic [6:0]  r_crc;
    logic        w_accept;
    logic        w_crc_rst;
    logic        w_crc_en;
    logic        w_crc_data;
    logic        w_crc_fb;

    // The done cycle is excluded so a held start is taken one cycle later.
    assign w_accept   = bus.i_start && (r_state == StIdle) && !r_done;
    assign w_crc_rst  = w_accept;
    assign w_crc_en   = (r_state == StHdr) && bus.i_bit_ce;
    assign w_crc_data = r_shift[39];
    assign w_crc_fb   = w_crc_data ^ r_crc[6];

    always_ff @(posedge i_clk) begin
        if (i_rst || w_crc_rst) begin
            r_crc <= 7'd0;
        end else if (w_crc_en) begin
            r_crc <= {r_crc[5:0], 1'b0} ^ ({7{w_crc_fb}} & 7'h09);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_shift   <= 40'd0;
            r_crc_sr  <= 7'd0;
            r_cnt     <= 6'd0;
            r_cmd_out <= 1'b1;
            r_cmd_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // A strobe coinciding with accept is deliberately unused.
                    if (w_accept) begin
                        r_shift <= {2'b01, bus.i_cmd_index, bus.i_arg};
                        r_cnt   <= 6'd0;
                        r_busy  <= 1'b1;
                        r_state <= StHdr;
                    end
                end
                StHdr: begin
                    if (bus.i_bit_ce) begin
                        r_cmd_out <= r_shift[39];
                        r_cmd_oe  <= 1'b1;
                        r_shift   <= {r_shift[38:0], 1'b0};
                        if (r_cnt == 6'd39) begin
                            r_cnt   <= 6'd0;
                            r_state <= StCrc;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                StCrc: begin
                    if (bus.i_bit_ce) begin
                        // CRC settled on the last header strobe; snapshot it now.
                        if (r_cnt == 6'd0) begin
                            r_cmd_out <= r_crc[6];
                            r_crc_sr  <= {r_crc[5:0], 1'b0};
                        end else begin
                            r_cmd_out <= r_crc_sr[6];
                            r_crc_sr  <= {r_crc_sr[5:0], 1'b0};
                        end
                        if (r_cnt == 6'd6) begin
                            r_cnt   <= 6'd0;
                            r_state <= StEnd;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                StEnd: begin
                    if (bus.i_bit_ce) begin
                        r_cmd_out <= 1'b1;
                        r_state   <= StFin;
                    end
                end
                StFin: begin
                    // This strobe closes the end-bit period.
                    if (bus.i_bit_ce) begin
                        r_cmd_out <= 1'b1;
                        r_cmd_oe  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.o_cmd_out = r_cmd_out;
    assign bus.o_cmd_oe  = r_cmd_oe;
    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
endmodule

// File: tb/tb_sd_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_sd_cmd_tx
// Directed bench for sd_cmd_tx. Expected 48-bit frames are queued when a
// frame is accepted and popped when the monitor has collected 48 bits.
// -----------------------------------------------------------------------------
module tb_sd_cmd_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;

    sd_cmd_tx_if bus ();

    sd_cmd_tx dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [47:0] exp_q[$];
    logic [47:0] frame = '0;
    int          nbits = 0;
    int          done_cnt = 0;
    int          strobe_cnt = 0;
    int          crcen_cnt = 0;
    int          base = 0;
    logic        ce_d = 1'b0;
    logic        rst_d = 1'b1;
    logic        prev_out = 1'b1;
    logic        prev_oe = 1'b0;
    int unsigned gap_lo = 4;
    int unsigned gap_hi = 4;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit strobe: period drawn from [gap_lo, gap_hi] clocks, high for one clock.
    initial begin
        bus.i_bit_ce = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus.i_bit_ce = 1'b1;
            @(posedge clk);
            #1 bus.i_bit_ce = 1'b0;
            repeat ($urandom_range(gap_hi, gap_lo) - 2) @(posedge clk);
        end
    end

    always @(posedge clk) begin
        ce_d  <= bus.i_bit_ce;
        rst_d <= rst;
        if (bus.i_bit_ce) strobe_cnt <= strobe_cnt + 1;
        if (rst || bus.o_done) crcen_cnt <= 0;
        else if (dut.w_crc_en) crcen_cnt <= crcen_cnt + 1;
    end

    // Monitor: collects driven bits at strobe edges, checks hold between strobes.
    always @(negedge clk) begin
        if (rst_d) begin
            nbits = 0;
        end else begin
            if (!ce_d && (bus.o_cmd_out !== prev_out || bus.o_cmd_oe !== prev_oe))
                check("off_strobe_change", {bus.o_cmd_out, bus.o_cmd_oe}, {prev_out, prev_oe});
            if (ce_d && bus.o_cmd_oe) begin
                frame = {frame[46:0], bus.o_cmd_out};
                nbits++;
                if (nbits == 48) begin
                    nbits = 0;
                    if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
                    else check("frame", frame, exp_q.pop_front());
                end
            end
            if (bus.o_done) begin
                check("crc_en_cycles", crcen_cnt, 40);
                check("done_frame_complete", nbits, 0);
                done_cnt++;
            end
        end
        prev_out = bus.o_cmd_out;
        prev_oe  = bus.o_cmd_oe;
    end

    task automatic send(input logic [5:0] idx, input logic [31:0] a, input logic [47:0] exp);
        bit ok = 1'b0;
        bus.i_start     = 1'b1;
        bus.i_cmd_index = idx;
        bus.i_arg       = a;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.i_start     = 1'b0;
        bus.i_cmd_index = idx ^ 6'h3f;
        bus.i_arg       = ~a;
        check("accept", ok, 1);
        exp_q.push_back(exp);
        base = strobe_cnt;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", ok, 1);
        if (ok) begin
            check("strobes_to_done", strobe_cnt - base, 49);
            check("done_oe_low", bus.o_cmd_oe, 0);
            check("done_out_high", bus.o_cmd_out, 1);
        end
    endtask

    task automatic idle_check();
        @(posedge clk);
        #1;
        check("done_one_cycle", bus.o_done, 0);
        check("busy_low_after_done", bus.o_busy, 0);
    endtask

    initial begin
        bit seen;
        bit ok;
        int d0;
        bus.i_start     = 1'b0;
        bus.i_cmd_index = 6'd0;
        bus.i_arg       = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_out", bus.o_cmd_out, 1);
        check("rst_cmd_oe", bus.o_cmd_oe, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        rst = 1'b0;

        send(6'd0, 32'h0000_0000, 48'h40_0000_0000_95);
        wait_done();
        idle_check();
        send(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87);
        wait_done();
        idle_check();
        send(6'd55, 32'h0000_0000, 48'h77_0000_0000_65);
        wait_done();

        // Back-to-back: start raised in the done cycle and held.
        bus.i_start     = 1'b1;
        bus.i_cmd_index = 6'd41;
        bus.i_arg       = 32'h4000_0000;
        @(posedge clk);
        #1;
        check("start_ignored_in_done", bus.o_busy, 0);
        @(posedge clk);
        #1;
        check("b2b_accept", bus.o_busy, 1);
        bus.i_start     = 1'b0;
        bus.i_cmd_index = 6'd0;
        bus.i_arg       = 32'hFFFF_FFFF;
        exp_q.push_back(48'h69_4000_0000_77);
        base = strobe_cnt;

        // Start pulse and new operands while busy must be ignored.
        repeat (40) @(posedge clk);
        #1;
        bus.i_start     = 1'b1;
        bus.i_cmd_index = 6'd17;
        bus.i_arg       = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        wait_done();
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_busy) seen = 1'b1;
        end
        check("no_extra_frame", seen, 0);

        // Reset after bit 20 of a CMD17 frame.
        send(6'd17, 32'h0000_0000, 48'h51_0000_0000_55);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (nbits == 20) begin
                ok = 1'b1;
                break;
            end
        end
        check("reached_bit20", ok, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_cmd_oe", bus.o_cmd_oe, 0);
        check("midrst_cmd_out", bus.o_cmd_out, 1);
        check("midrst_busy", bus.o_busy, 0);
        rst = 1'b0;
        void'(exp_q.pop_back());
        d0 = done_cnt;
        repeat (200) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt, d0);
        send(6'd17, 32'h0000_0000, 48'h51_0000_0000_55);
        wait_done();
        idle_check();

        // Irregular strobe spacing.
        gap_lo = 2;
        gap_hi = 9;
        send(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87);
        wait_done();
        idle_check();
        send(6'd0, 32'h0000_0000, 48'h40_0000_0000_95);
        wait_done();
        idle_check();

        repeat (5) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("done_count", done_cnt, 7);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
